// File: rtl/matrix_ram_writer.sv
// Writeback stage: snapshots an N x N signed result matrix and streams it row-major to RAM.
// Optional WB_CHECKSUM_EN adds a running modulo-2^DATA_W checksum output.
module matrix_ram_writer #(
  parameter int N      = 10,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic signed [DATA_W-1:0] in_matrix [N][N],
  output logic                     busy,
  output logic                     done,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready
`ifdef WB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]        checksum
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FIN
  } state_t;

  state_t state;

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] nrow;
  logic [CW-1:0] ncol;
  logic          accept;
  logic          xfer;
  logic          last;

  logic signed [DATA_W-1:0] snap [N][N];

  assign accept = (state == IDLE) && start;
  assign xfer   = (state == WRITE) && mem_ready;
  assign last   = (row == LAST) && (col == LAST);

  // Next row/column position in row-major order.
  always_comb begin
    nrow = row;
    ncol = col + 1'b1;
    if (col == LAST) begin
      ncol = '0;
      nrow = row + 1'b1;
    end
  end

  // Snapshot the matrix on acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap <= in_matrix;
    end
  end

  // Control FSM with registered RAM port and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= WRITE;
            row       <= '0;
            col       <= '0;
            busy      <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= base_addr;
            // Snapshot is written on this same edge, so take word 0 directly.
            mem_wdata <= in_matrix[0][0];
          end
        end
        WRITE: begin
          if (mem_ready) begin
            if (last) begin
              state  <= FIN;
              mem_we <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              row       <= nrow;
              col       <= ncol;
              // Incrementing equals base + row*N + col modulo 2^ADDR_W.
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_wdata <= snap[nrow][ncol];
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_CHECKSUM_EN
  // Running sum of accepted words, restarted on each new transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + mem_wdata;
    end
  end
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_matrix_ram_writer.sv
// Directed self-checking bench for matrix_ram_writer.
// Define WB_CHECKSUM_EN to also check the checksum output.
module tb_matrix_ram_writer;

  localparam int N = 10;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [15:0]              base_addr;
  logic signed [15:0]       tb_mat [N][N];
  logic                     busy;
  logic                     done;
  logic                     mem_we;
  logic [15:0]              mem_addr;
  logic [15:0]              mem_wdata;
  logic                     mem_ready;
`ifdef WB_CHECKSUM_EN
  logic [15:0]              checksum;
`endif

  logic signed [15:0] exp_mat [N][N];
  logic [15:0]        exp_base;
  int                 n_assert;
  int                 n_fail;

  matrix_ram_writer #(.N(N), .DATA_W(16), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_matrix (tb_mat),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready)
`ifdef WB_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       tb_mat[i][j] = 16'(i + j);
          1:       tb_mat[i][j] = -16'sd1;
          2:       tb_mat[i][j] = 16'((i * 10 + j) * 331 - 16000);
          default: tb_mat[i][j] = 16'h7777;
        endcase
      end
    end
  endtask

  task automatic start_xfer(input logic [15:0] b, input bit hold);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_we", {31'd0, mem_we}, 32'd0);
    base_addr = b;
    start     = 1'b1;
    exp_base  = b;
    exp_mat   = tb_mat;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic run_xfer(input bit toggle, input int inject_at, input int done_cyc);
    int          k;
    int          cyc;
    bit          rdy;
    bit          injected;
    logic [15:0] sum;
    logic [15:0] word;
    logic [15:0] ea;
    k        = 0;
    cyc      = 1;
    injected = 1'b0;
    sum      = '0;
    while (k < N * N && cyc < 1000) begin
      rdy       = toggle ? (cyc % 2 == 1) : 1'b1;
      mem_ready = rdy;
      if (inject_at == k && !injected) begin
        injected  = 1'b1;
        start     = 1'b1;
        base_addr = 16'h0BAD;
        fill(3);
      end else if (injected) begin
        start = 1'b0;
      end
      word = exp_mat[k / N][k % N];
      ea   = exp_base + 16'(k);
      chk("wr_busy", {31'd0, busy}, 32'd1);
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      chk("wr_addr", {16'd0, mem_addr}, {16'd0, ea});
      chk("wr_data", {16'd0, mem_wdata}, {16'd0, word});
      chk("wr_done", {31'd0, done}, 32'd0);
`ifdef WB_CHECKSUM_EN
      chk("wr_csum", {16'd0, checksum}, {16'd0, sum});
`endif
      @(posedge clk);
      #1;
      if (rdy) begin
        sum = sum + word;
        k++;
      end
      cyc++;
    end
    chk("done_cycle", cyc, done_cyc);
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_busy", {31'd0, busy}, 32'd0);
    chk("fin_we", {31'd0, mem_we}, 32'd0);
`ifdef WB_CHECKSUM_EN
    chk("fin_csum", {16'd0, checksum}, {16'd0, sum});
`endif
    @(posedge clk);
    #1;
    chk("post_done", {31'd0, done}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_we", {31'd0, mem_we}, 32'd0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    mem_ready = 1'b0;
    fill(0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_data", {16'd0, mem_wdata}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    fill(0);
    start_xfer(16'h0100, 1'b0);
    run_xfer(1'b0, -1, 101);

    fill(0);
    start_xfer(16'h0100, 1'b0);
    run_xfer(1'b1, -1, 200);

    fill(2);
    start_xfer(16'hFFFA, 1'b0);
    run_xfer(1'b0, -1, 101);

    fill(0);
    start_xfer(16'h0400, 1'b0);
    run_xfer(1'b1, 50, 200);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("ign_done", {31'd0, done}, 32'd0);
      chk("ign_we", {31'd0, mem_we}, 32'd0);
    end

    fill(1);
    start_xfer(16'h0500, 1'b0);
    run_xfer(1'b0, -1, 101);

    fill(2);
    mem_ready = 1'b1;
    start_xfer(16'h2000, 1'b1);
    run_xfer(1'b0, -1, 101);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_we", {31'd0, mem_we}, 32'd1);
    chk("b2b_addr", {16'd0, mem_addr}, 32'h2000);
    chk("b2b_data", {16'd0, mem_wdata}, {16'd0, exp_mat[0][0]});
    repeat (37) @(posedge clk);
    #1;
    chk("pre_rst_addr", {16'd0, mem_addr}, 32'h2025);
    chk("pre_rst_data", {16'd0, mem_wdata}, {16'd0, exp_mat[3][7]});
    rst = 1'b0;
    #1;
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_addr", {16'd0, mem_addr}, 32'd0);
    chk("arst_data", {16'd0, mem_wdata}, 32'd0);
`ifdef WB_CHECKSUM_EN
    chk("arst_csum", {16'd0, checksum}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("after_rst_we", {31'd0, mem_we}, 32'd0);
      chk("after_rst_busy", {31'd0, busy}, 32'd0);
    end

    fill(0);
    start_xfer(16'h0300, 1'b0);
    run_xfer(1'b0, -1, 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_ram_writer.md
Name: matrix_ram_writer

Overview:
- Writeback end of the NPU datapath: takes the final 10x10 signed 16-bit result matrix and stores it word by word into data RAM at a new base address.
- It is the writer counterpart to the matrix loader that fills A from RAM.
- Sits after normalization in npu_top_module. It snapshots the matrix on start, then streams it row-major over a valid/ready RAM write port.

Parameters:
- N, 10, matrix dimension (N x N words written).
- DATA_W, 16, word width in bits (signed).
- ADDR_W, 16, RAM word-address width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request writeback; sampled only in IDLE.
- base_addr  input  ADDR_W  first RAM word address; latched on accepted start.
- in_matrix  input  N*N x DATA_W (unpacked [N][N], signed)  result matrix; latched on accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last word is accepted.
- mem_we  output  1  write request (valid).
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- mem_ready  input  1  RAM accepts the write on this edge when mem_we is also high.

Behaviour:
- Reset (rst low, any time, including mid-transfer): state IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0; counters cleared. No further writes are issued; the partial transfer is abandoned.
- States: IDLE, WRITE, FIN.
- IDLE:
  - start=1 copies in_matrix into an internal snapshot buffer and latches base_addr.
  - Sets row=0, col=0 and moves to WRITE.
  - Next cycle: busy=1, mem_we=1, mem_addr=base, mem_wdata=snap[0][0].
- WRITE:
  - mem_we stays high.
  - A word is transferred on each edge where mem_we && mem_ready.
  - While mem_ready=0, mem_addr and mem_wdata hold stable (stall, unbounded).
  - On transfer, advance col. At col=N-1, col wraps to 0 and row increments.
  - Address = base + row*N + col, computed modulo 2^ADDR_W; wrap past max address is silent.
  - The transfer of word (N-1,N-1) moves to FIN; mem_we drops the same edge.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Throughput and latency with mem_ready held high:
  - 1 word/cycle.
  - Start accepted at edge 0; writes occupy cycles 1..N*N.
  - done is high in cycle N*N+1.
- start while busy or in FIN is ignored; no queuing.
- in_matrix and base_addr changes after acceptance have no effect on the transfer in progress.
- start held high continuously: a new transfer begins in the first IDLE cycle after FIN. This gives back-to-back transfers with one idle cycle between them.
- Data is passed bit-exact; no sign or width change.

Optional Feature:
- Macro: WB_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [DATA_W-1:0].
  - Holds the modulo-2^DATA_W sum of all words accepted in the current transfer.
  - Cleared to 0 on reset and on start acceptance; updated on each accepted word.
  - Final value is valid from the done cycle and holds until the next start is accepted.
- Undefined: no checksum port or logic; all other behaviour is identical.

Test Plan:
- Reset, then start with base_addr=0x0100, in_matrix[i][j]=i+j, mem_ready=1 -> 100 writes at 0x0100..0x0163; word k = (k/10)+(k%10); done pulses in cycle 101; busy high cycles 1..100.
- Same stimulus with mem_ready toggling 1,0,1,0 -> every address and data value still written exactly once, in order; addr/data stable during low-ready cycles; done in cycle 200.
- base_addr=0xFFFA with ADDR_W=16 -> writes at 0xFFFA..0xFFFF then 0x0000..0x005D; no dropped or duplicated words.
- Second start pulse at write 50 with different base_addr and matrix -> ignored; first transfer completes unchanged; exactly one done pulse.
- rst low at write 37 -> mem_we=0, busy=0, done=0 within the reset cycle; no writes after reset until a new start; the new start begins again at word (0,0).
- WB_CHECKSUM_EN defined, in_matrix[i][j]=i+j -> checksum=900 (0x0384) at done; with all words -1 -> checksum=0xFF9C.
